// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetris game sequencer: board command codes,
// piece identifiers, player-input bit positions, line-clear scoring and randomizer settings.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_DOWN   = 3'd4,
    CMD_SPAWN  = 3'd5,
    CMD_CLEAR  = 3'd6,
    CMD_RESET  = 3'd7
  } cmd_code_t;

  localparam logic [2:0] PIECE_LEN      = 3'd1;
  localparam logic [2:0] PIECE_SKEW     = 3'd2;
  localparam logic [2:0] PIECE_T        = 3'd3;
  localparam logic [2:0] PIECE_L        = 3'd4;
  localparam logic [2:0] PIECE_BLOCK    = 3'd5;
  localparam logic [2:0] PIECE_SKEWEN   = 3'd6;
  localparam logic [2:0] PIECE_STRAIGHT = 3'd7;

  localparam int OP_RIGHT  = 0;
  localparam int OP_LEFT   = 1;
  localparam int OP_DOWN   = 2;
  localparam int OP_ROTATE = 3;
  localparam int OP_START  = 4;

  localparam logic [3:0] SCORE_INC_1 = 4'd1;
  localparam logic [3:0] SCORE_INC_2 = 4'd3;
  localparam logic [3:0] SCORE_INC_3 = 4'd7;
  localparam logic [3:0] SCORE_INC_4 = 4'd10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One move per frame: ROTATE beats DOWN beats a single horizontal move;
  // LEFT and RIGHT together cancel out.
  function automatic cmd_code_t arbitrate_op(input logic [4:0] op);
    cmd_code_t c;
    c = CMD_NOP;
    if (op[OP_ROTATE])
      c = CMD_ROTATE;
    else if (op[OP_DOWN])
      c = CMD_DOWN;
    else if (op[OP_LEFT] != op[OP_RIGHT])
      c = op[OP_LEFT] ? CMD_LEFT : CMD_RIGHT;
    return c;
  endfunction

  function automatic logic [3:0] line_score(input logic [2:0] lines);
    logic [3:0] inc;
    case (lines)
      3'd1:    inc = SCORE_INC_1;
      3'd2:    inc = SCORE_INC_2;
      3'd3:    inc = SCORE_INC_3;
      3'd4:    inc = SCORE_INC_4;
      default: inc = 4'd0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/tetris_piece_rng.sv
// Piece randomizer: 16-bit Galois LFSR stepped once per spawn; the low three bits
// select the piece, with the all-zero pattern remapped to the straight piece.
module tetris_piece_rng
  import tetris_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       advance,
  output logic [2:0] piece
);

  logic [15:0] lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      lfsr <= LFSR_SEED;
    else if (advance)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign piece = (lfsr[2:0] == 3'd0) ? PIECE_STRAIGHT : lfsr[2:0];

endmodule

// File: rtl/tetris_game_sequencer.sv
// Game controller: turns frame-synchronous player input and gravity into a serialized
// board command stream. Optional pause support is built when TETRIS_PAUSE_EN is defined.
module tetris_game_sequencer
  import tetris_pkg::*;
#(
  parameter int GRAVITY_FRAMES = 6,
  parameter int SCORE_W        = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic [4:0]         operation,
  output logic               cmd_req,
  output logic [2:0]         cmd_code,
  output logic [2:0]         cmd_piece,
  input  logic               cmd_done,
  input  logic               cmd_blocked,
  input  logic [2:0]         cmd_lines,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               gameover,
  output logic [3:0]         fsm_state
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RESET_BD = 4'd1;
  localparam logic [3:0] SPAWN    = 4'd2;
  localparam logic [3:0] PLAY     = 4'd3;
  localparam logic [3:0] USER     = 4'd4;
  localparam logic [3:0] GRAV     = 4'd5;
  localparam logic [3:0] CLEAR    = 4'd6;
  localparam logic [3:0] OVER     = 4'd7;
`ifdef TETRIS_PAUSE_EN
  localparam logic [3:0] PAUSE    = 4'd8;
`endif

  localparam logic [5:0] GRAV_LAST = 6'(GRAVITY_FRAMES - 1);

  logic [3:0]         state;
  logic [2:0]         vsync_sync;
  logic               frame_start;
  logic [5:0]         frame_cnt;
  logic               grav_pend;
  cmd_code_t          op_pend;
  cmd_code_t          cur_op;
  cmd_code_t          issue_code;
  logic               counting;
  logic               cmd_state;
  logic               issue;
  logic               finish;
  logic [2:0]         rng_piece;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
`ifdef TETRIS_PAUSE_EN
  logic               pause_req;
`endif

  // Two flops resynchronize vsync; the third holds the previous level for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      vsync_sync <= 3'b000;
    else
      vsync_sync <= {vsync_sync[1:0], vsync};
  end

  assign frame_start = vsync_sync[1] & ~vsync_sync[2];

  assign counting  = (state == PLAY) || (state == USER) || (state == GRAV) || (state == CLEAR);
  assign cmd_state = (state == RESET_BD) || (state == SPAWN) || (state == USER) ||
                     (state == GRAV) || (state == CLEAR);

  // Handshake: cmd_req rises the cycle after a command state is entered and holds
  // cmd_code/cmd_piece steady until a cycle where cmd_done is high; it drops on the
  // following edge, together with the state change. cmd_done with cmd_req low is ignored.
  assign issue  = cmd_state && !cmd_req;
  assign finish = cmd_req && cmd_done;

  always_comb begin
    issue_code = CMD_NOP;
    case (state)
      RESET_BD: issue_code = CMD_RESET;
      SPAWN:    issue_code = CMD_SPAWN;
      USER:     issue_code = cur_op;
      GRAV:     issue_code = CMD_DOWN;
      CLEAR:    issue_code = CMD_CLEAR;
      default:  issue_code = CMD_NOP;
    endcase
  end

  assign score_sum  = {1'b0, score} + {{(SCORE_W-3){1'b0}}, line_score(cmd_lines)};
  assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  tetris_piece_rng u_rng (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (issue && (state == SPAWN)),
    .piece   (rng_piece)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_req   <= 1'b0;
      cmd_code  <= CMD_NOP;
      cmd_piece <= 3'd0;
      score     <= '0;
      frame_cnt <= 6'd0;
      grav_pend <= 1'b0;
      op_pend   <= CMD_NOP;
      cur_op    <= CMD_NOP;
`ifdef TETRIS_PAUSE_EN
      pause_req <= 1'b0;
`endif
    end else begin
      if (issue) begin
        cmd_req   <= 1'b1;
        cmd_code  <= issue_code;
        cmd_piece <= (state == SPAWN) ? rng_piece : 3'd0;
      end
      if (finish) begin
        cmd_req   <= 1'b0;
        cmd_code  <= CMD_NOP;
        cmd_piece <= 3'd0;
      end

      case (state)
        IDLE, OVER: if (frame_start && operation[OP_START]) state <= RESET_BD;
        RESET_BD: begin
          if (finish) begin
            score <= '0;
            state <= SPAWN;
          end
        end
        SPAWN: if (finish) state <= cmd_blocked ? OVER : PLAY;
        PLAY: begin
`ifdef TETRIS_PAUSE_EN
          if (pause_req) begin
            pause_req <= 1'b0;
            op_pend   <= CMD_NOP;
            grav_pend <= 1'b0;
            state     <= PAUSE;
          end else
`endif
          if (op_pend != CMD_NOP) begin
            cur_op  <= op_pend;
            op_pend <= CMD_NOP;
            state   <= USER;
          end else if (grav_pend) begin
            grav_pend <= 1'b0;
            state     <= GRAV;
          end
        end
        USER: if (finish) state <= PLAY;
        GRAV: if (finish) state <= cmd_blocked ? CLEAR : PLAY;
        CLEAR: begin
          if (finish) begin
            score <= score_next;
            state <= SPAWN;
          end
        end
`ifdef TETRIS_PAUSE_EN
        PAUSE: if (frame_start && operation[OP_START]) state <= PLAY;
`endif
        default: state <= IDLE;
      endcase

      // Placed after the state case so a frame landing in the same cycle that PLAY
      // consumes the pending work re-arms it rather than being lost.
      if (frame_start && counting) begin
`ifdef TETRIS_PAUSE_EN
        if (operation[OP_START])
          pause_req <= 1'b1;
        else
`endif
        begin
          op_pend <= arbitrate_op(operation);
          if (frame_cnt == GRAV_LAST) begin
            frame_cnt <= 6'd0;
            grav_pend <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 6'd1;
          end
        end
      end
    end
  end

  assign playing   = (state == SPAWN) || counting;
  assign gameover  = (state == OVER);
  assign fsm_state = state;

endmodule

// File: tb/tb_tetris_game_sequencer.sv
// Bench for tetris_game_sequencer: frame-level reference model feeds an expected
// command queue; a monitor checks each issued command, a responder plays the board engine.
module tb_tetris_game_sequencer;

  localparam int G    = 6;
  localparam int SMAX = 255;
  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_OVER  = 2;
  localparam int M_PAUSE = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic [4:0] operation;
  logic       cmd_req;
  logic [2:0] cmd_code;
  logic [2:0] cmd_piece;
  logic       cmd_done;
  logic       cmd_blocked;
  logic [2:0] cmd_lines;
  logic [7:0] score;
  logic       playing;
  logic       gameover;
  logic [3:0] fsm_state;

  tetris_game_sequencer #(.GRAVITY_FRAMES(G), .SCORE_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .operation   (operation),
    .cmd_req     (cmd_req),
    .cmd_code    (cmd_code),
    .cmd_piece   (cmd_piece),
    .cmd_done    (cmd_done),
    .cmd_blocked (cmd_blocked),
    .cmd_lines   (cmd_lines),
    .score       (score),
    .playing     (playing),
    .gameover    (gameover),
    .fsm_state   (fsm_state)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  logic [5:0] exp_q[$];

  // Board-engine behaviour knobs, written only by the main stimulus process.
  int down_block  = 0;
  int spawn_block = 0;
  int clear_lines = 0;
  int fixed_lat   = 0;
  int spur_req    = 0;

  // Reference model state.
  logic [15:0] m_lfsr;
  int m_score;
  int m_cnt;
  int m_mode;

  function automatic logic [2:0] m_piece();
    logic [2:0] p;
    p = m_lfsr[2:0];
    if (p == 3'd0) p = 3'd7;
    return p;
  endfunction

  function automatic void m_advance();
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else           m_lfsr = m_lfsr >> 1;
  endfunction

  function automatic logic [2:0] m_arb(input logic [4:0] op);
    if (op[3]) return 3'd3;
    if (op[2]) return 3'd4;
    if (op[1] && !op[0]) return 3'd1;
    if (op[0] && !op[1]) return 3'd2;
    return 3'd0;
  endfunction

  function automatic int m_inc(input int lines);
    case (lines)
      1: return 1;
      2: return 3;
      3: return 7;
      4: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_step();
    bit g;
    g = (m_cnt == G - 1);
    m_cnt = g ? 0 : m_cnt + 1;
    return g;
  endfunction

  function automatic void m_spawn();
    exp_q.push_back({3'd5, m_piece()});
    m_advance();
    m_mode = spawn_block ? M_OVER : M_PLAY;
  endfunction

  // What one frame does when the sequencer is at rest.
  function automatic void model_frame(input logic [4:0] op);
    logic [2:0] a;
    bit g;
    case (m_mode)
      M_IDLE, M_OVER: begin
        if (op[4]) begin
          exp_q.push_back({3'd7, 3'd0});
          m_score = 0;
          m_spawn();
        end
      end
      M_PAUSE: if (op[4]) m_mode = M_PLAY;
      default: begin
`ifdef TETRIS_PAUSE_EN
        if (op[4]) begin
          m_mode = M_PAUSE;
          return;
        end
`endif
        a = m_arb(op);
        g = m_step();
        if (a != 3'd0) exp_q.push_back({a, 3'd0});
        if (g) begin
          exp_q.push_back({3'd4, 3'd0});
          if (down_block != 0) begin
            exp_q.push_back({3'd6, 3'd0});
            m_score = m_score + m_inc(clear_lines);
            if (m_score > SMAX) m_score = SMAX;
            m_spawn();
          end
        end
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic frame_raw(input logic [4:0] op);
    operation = op;
    @(negedge clock);
    vsync = 1'b1;
    repeat (3) @(negedge clock);
    vsync = 1'b0;
    repeat (5) @(negedge clock);
    operation = 5'd0;
  endtask

  task automatic frame(input logic [4:0] op);
    model_frame(op);
    frame_raw(op);
  endtask

  task automatic settle();
    int idle;
    int t;
    idle = 0;
    t = 0;
    while ((exp_q.size() != 0 || idle < 12) && t < 3000) begin
      @(negedge clock);
      t++;
      if (cmd_req || exp_q.size() != 0) idle = 0;
      else idle++;
    end
    if (t >= 3000) begin
      compared++;
      mismatched++;
      $display("FAIL settle_timeout: got %0d commands still outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_state();
    check("score", 32'(score), 32'(m_score));
    check("playing", 32'(playing), 32'(m_mode == M_PLAY));
    check("gameover", 32'(gameover), 32'(m_mode == M_OVER));
  endtask

  // Monitor: every new command is popped from the expected queue and compared.
  initial begin
    logic prev;
    logic [5:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev = 1'b0;
      end else begin
        if (cmd_req && !prev) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL cmd_unexpected: got code %0d piece %0d, required no command", cmd_code, cmd_piece);
          end else begin
            e = exp_q.pop_front();
            if ({cmd_code, cmd_piece} !== e) begin
              mismatched++;
              $display("FAIL cmd_stream: got code %0d piece %0d, required code %0d piece %0d",
                       cmd_code, cmd_piece, e[5:3], e[2:0]);
            end
          end
        end
        prev = cmd_req;
      end
    end
  end

  // Board engine stand-in.
  initial begin
    int lat;
    int spur_ack;
    logic [2:0] code;
    spur_ack = 0;
    cmd_done = 1'b0;
    cmd_blocked = 1'b0;
    cmd_lines = 3'd0;
    forever begin
      @(negedge clock);
      if (reset_n && cmd_req) begin
        lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(0, 10);
        code = cmd_code;
        repeat (lat) @(negedge clock);
        if (reset_n && cmd_req) begin
          cmd_done = 1'b1;
          case (code)
            3'd4:    cmd_blocked = (down_block != 0);
            3'd5:    cmd_blocked = (spawn_block != 0);
            3'd6:    cmd_lines = 3'(clear_lines);
            3'd7:    cmd_blocked = 1'b0;
            default: cmd_blocked = 1'($urandom_range(0, 1));
          endcase
          @(negedge clock);
          cmd_done = 1'b0;
          cmd_blocked = 1'b0;
          cmd_lines = 3'd0;
        end
      end else if (spur_ack != spur_req) begin
        spur_ack = spur_req;
        cmd_done = 1'b1;
        cmd_blocked = 1'b1;
        cmd_lines = 3'd4;
        @(negedge clock);
        cmd_done = 1'b0;
        cmd_blocked = 1'b0;
        cmd_lines = 3'd0;
      end
    end
  end

  initial begin
    #900000;
    mismatched++;
    $display("FAIL watchdog: got no end of stimulus, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    logic [4:0] o;
    logic [2:0] last;
    bit g;
    reset_n = 1'b0;
    vsync = 1'b0;
    operation = 5'd0;
    m_lfsr = 16'hACE1;
    m_score = 0;
    m_cnt = 0;
    m_mode = M_IDLE;

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_cmd_req", 32'(cmd_req), 0);
    check("rst_cmd_code", 32'(cmd_code), 0);
    check("rst_cmd_piece", 32'(cmd_piece), 0);
    check("rst_score", 32'(score), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_gameover", 32'(gameover), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // IDLE ignores non-START frames, START launches RESET then SPAWN.
    frame(5'b01111); settle(); check_state();
    frame(5'b10000); settle(); check_state();

    // Gravity alone: one DOWN per G frames, then a locked piece clearing two lines.
    for (int i = 0; i < 2 * G; i++) begin frame(5'd0); settle(); end
    check_state();
    down_block = 1; clear_lines = 2;
    for (int i = 0; i < G; i++) begin frame(5'd0); settle(); end
    check_state();
    down_block = 0; clear_lines = 0;

    // Arbitration patterns, plus START while in play (pause toggle when enabled).
    frame(5'b01011); settle(); check_state();
    frame(5'b00011); settle(); check_state();
    frame(5'b00110); settle(); check_state();
    frame(5'b00010); settle(); check_state();
    frame(5'b00001); settle(); check_state();
    frame(5'b10000); settle(); check_state();
    for (int i = 0; i < 8; i++) begin frame(5'd0); settle(); end
    frame(5'b10000); settle(); check_state();

    // Frames while a slow command is outstanding: last op kept, gravity not doubled.
    fixed_lat = 150;
    exp_q.push_back({3'd3, 3'd0});
    g = m_step();
    last = 3'd0;
    frame_raw(5'b01000);
    for (int k = 0; k < G; k++) begin
      o = 5'd1 << $urandom_range(0, 3);
      last = m_arb(o);
      g = g | m_step();
      frame_raw(o);
    end
    fixed_lat = 0;
    exp_q.push_back({last, 3'd0});
    if (g) exp_q.push_back({3'd4, 3'd0});
    settle(); check_state();

    // Randomized play.
    for (int i = 0; i < 200; i++) begin
      down_block  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      clear_lines = $urandom_range(0, 4);
      spawn_block = ($urandom_range(0, 19) == 0) ? 1 : 0;
      o = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) o[4] = 1'b1;
      if (m_mode == M_OVER && $urandom_range(0, 2) == 0) o[4] = 1'b1;
      frame(o);
      settle();
      check_state();
      if ($urandom_range(0, 9) == 0) begin
        spur_req++;
        repeat (3) @(negedge clock);
        settle();
        check_state();
      end
    end

    // Force a game over, restart at score 0, then drive four-line clears to saturation.
    if (m_mode == M_PAUSE) begin frame(5'b10000); settle(); end
    down_block = 1; spawn_block = 1; clear_lines = 0;
    for (int i = 0; i < 20 && m_mode == M_PLAY; i++) begin frame(5'd0); settle(); end
    check_state();
    spawn_block = 0;
    if (m_mode != M_PLAY) begin frame(5'b10000); settle(); end
    check_state();
    clear_lines = 4;
    for (int i = 0; i < 200 && m_score < SMAX; i++) begin frame(5'd0); settle(); check_state(); end
    check("score_saturated", 32'(score), 32'(SMAX));

    // Blocked spawn ends the game; only START gets out of OVER.
    spawn_block = 1;
    for (int i = 0; i < 20 && m_mode == M_PLAY; i++) begin frame(5'd0); settle(); end
    check_state();
    spawn_block = 0;
    frame(5'b01111); settle(); check_state();
    frame(5'b00100); settle(); check_state();
    frame(5'b10000); settle(); check_state();

    // Asynchronous reset in the middle of a command.
    down_block = 0;
    fixed_lat = 100;
    frame(5'b01000);
    check("long_cmd_pending", 32'(cmd_req), 1);
    #2 reset_n = 1'b0;
    #1 check("async_rst_cmd_req", 32'(cmd_req), 0);
    check("async_rst_cmd_code", 32'(cmd_code), 0);
    check("async_rst_score", 32'(score), 0);
    exp_q.delete();
    m_lfsr = 16'hACE1;
    m_score = 0;
    m_cnt = 0;
    m_mode = M_IDLE;
    fixed_lat = 0;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (120) @(negedge clock);
    check_state();
    frame(5'b10000); settle(); check_state();
    for (int i = 0; i < G; i++) begin frame(5'd0); settle(); end
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tetris_game_sequencer.md
# tetris_game_sequencer

Top-level game controller for the board datapath: turns frame-synchronous player input and a frame-counted gravity tick into a serialized stream of board commands over a req/done handshake. Owns the play/lock/line-clear/score/spawn/game-over sequence, the piece randomizer and the score register. Sits between the input/VGA timing logic (operation, vsync) and the board engine that holds the 10x20 playfield.

## Interface
- GRAVITY_FRAMES, 6: vsync frames per gravity tick (legal 1..63).
- SCORE_W, 8: score register width.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  frame strobe, asynchronous to game state; synchronized internally (2 flops), rising edge = frame start.
- operation  in  5  bit0 RIGHT, bit1 LEFT, bit2 DOWN, bit3 ROTATE, bit4 START; level, sampled at frame start.
- cmd_req  out  1  command valid; held until cmd_done.
- cmd_code  out  3  NOP 0, LEFT 1, RIGHT 2, ROTATE 3, DOWN 4, SPAWN 5, CLEAR 6, RESET 7; stable while cmd_req.
- cmd_piece  out  3  piece type for SPAWN (1..7), else 0.
- cmd_done  in  1  one-cycle completion pulse from board engine.
- cmd_blocked  in  1  valid with cmd_done: move/spawn refused (collision/boundary).
- cmd_lines  in  3  valid with cmd_done for CLEAR: rows removed, 0..4.
- score  out  SCORE_W  accumulated score.
- playing  out  1  high in PLAY-side states.
- gameover  out  1  high in OVER.

## Operation
- States: IDLE, RESET_BD, SPAWN, PLAY, USER, GRAV, CLEAR, OVER (+ PAUSE if enabled).
- IDLE: wait START at a frame start -> RESET_BD. RESET_BD: issue RESET, on done clear score -> SPAWN.
- SPAWN: issue SPAWN with cmd_piece from randomizer; done&!blocked -> PLAY; done&blocked -> OVER. Randomizer advances once per SPAWN.
- Frame start in PLAY: latch one user op and set grav_pend when frame counter reaches GRAVITY_FRAMES-1 (counter wraps to 0). Counter runs only in PLAY/USER/GRAV/CLEAR.
- User arbitration (one per frame): ROTATE > DOWN > LEFT/RIGHT; LEFT and RIGHT both set -> neither; START ignored in play.
- PLAY priority: latched user op -> USER; else grav_pend -> GRAV. USER: issue op, blocked result ignored -> PLAY.
- GRAV: issue DOWN, clear grav_pend; !blocked -> PLAY; blocked -> CLEAR (piece locked).
- CLEAR: issue CLEAR; on done add increment 1/3/7/10 for 1/2/3/4 lines (0 otherwise); score saturates at 2^SCORE_W-1 -> SPAWN.
- OVER: gameover=1, frame counter held; START at frame start -> RESET_BD.
- Frame start arriving while a command is outstanding: latched op/grav_pend retained, a second frame start before service overwrites user op, grav_pend stays set (never lost, never doubled).

## Timing
- Reset: state IDLE, cmd_req 0, cmd_code 0, cmd_piece 0, score 0, playing 0, gameover 0, frame counter 0, grav_pend 0, LFSR seed 16'hACE1.
- vsync to frame-start detection: 3 clocks (2 sync + edge).
- cmd_req asserts the cycle after state entry; drops the cycle after cmd_done; next cmd_req no earlier than one idle cycle later.
- cmd_done while cmd_req low is ignored. Score updates the cycle after CLEAR done.
- Reset mid-command: cmd_req drops immediately (async); board engine must tolerate abandoned command.

## Configuration
- TETRIS_PAUSE_EN defined: START at frame start in PLAY -> PAUSE (playing 0, counter frozen, grav_pend/op discarded); START again -> PLAY. Outstanding command completes first.
- Undefined: no PAUSE state, START ignored in play.

## Structure
- tetris_pkg: cmd_code enum, piece-type constants (straight 7, L 4, LEn 1, Skew 2, SkewEn 6, Block 5, T 3), operation bit indices, score increment constants.
- Sub-module tetris_piece_rng: 16-bit Galois LFSR (taps 16,14,13,11), advance strobe, output 1..7 via reject-and-remap of 0 to 7.

## Test plan
- Reset, START pulse at frame -> RESET then SPAWN piece nonzero; playing=1, score 0.
- No input, GRAVITY_FRAMES=6: exactly one DOWN per 6 frames; DOWN blocked -> CLEAR, cmd_lines=2 -> score +3 then SPAWN.
- LEFT+RIGHT+ROTATE same frame -> only ROTATE issued; LEFT+RIGHT only -> no command.
- User op and gravity in same frame with 10-cycle done latency -> user command first, then DOWN; no extra DOWN.
- Score 250 plus 4-line clear -> 255 (saturated).
- SPAWN blocked -> gameover=1, no further commands; START -> RESET, score 0; with TETRIS_PAUSE_EN, START in play freezes gravity for N frames.
